// File: rtl/issue_scoreboard_pkg.sv
// Shared constants for the issue stage: function types, unit one-hot positions,
// FSM encoding and register index width.
package issue_scoreboard_pkg;

  localparam int REG_W         = 5;
  localparam int NUM_ARCH_REGS = 32;

  localparam logic [1:0] FT_NOP    = 2'd0;
  localparam logic [1:0] FT_ARITH  = 2'd1;
  localparam logic [1:0] FT_LDST   = 2'd2;
  localparam logic [1:0] FT_BRANCH = 2'd3;

  localparam int U_ARITH  = 0;
  localparam int U_LDST   = 1;
  localparam int U_BRANCH = 2;

  typedef enum logic [1:0] {
    ST_EMPTY       = 2'd0,
    ST_HOLD        = 2'd1,
    ST_BRANCH_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-side, execution-unit-side, writeback and status signals of the issue stage.
// The slave modport is the issue stage's view; master is the surrounding pipeline.
interface issue_scoreboard_if
  import issue_scoreboard_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             enable_i;
  logic [6:0]       opcode_i;
  logic [1:0]       functionType_i;
  logic [REG_W-1:0] primOperand_i;
  logic [15:0]      secOperand_i;
  logic             pRead_i;
  logic             pWrite_i;
  logic             sRead_i;
  logic             stall_o;
  logic [2:0]       unitValid_o;
  logic [2:0]       unitReady_i;
  logic [6:0]       opcode_o;
  logic [REG_W-1:0] primOperand_o;
  logic [15:0]      secOperand_o;
  logic             pRead_o;
  logic             pWrite_o;
  logic             sRead_o;
  logic             wbEnable_i;
  logic [REG_W-1:0] wbReg_i;
  logic             branchResolved_i;
  logic             protocolError_o;
  logic [CNT_W-1:0] issuedCount_o;
  logic [CNT_W-1:0] stallCycles_o;

  modport slave (
    input  enable_i, opcode_i, functionType_i, primOperand_i, secOperand_i,
    input  pRead_i, pWrite_i, sRead_i, unitReady_i,
    input  wbEnable_i, wbReg_i, branchResolved_i,
    output stall_o, unitValid_o, opcode_o, primOperand_o, secOperand_o,
    output pRead_o, pWrite_o, sRead_o, protocolError_o, issuedCount_o, stallCycles_o
  );

  modport master (
    output enable_i, opcode_i, functionType_i, primOperand_i, secOperand_i,
    output pRead_i, pWrite_i, sRead_i, unitReady_i,
    output wbEnable_i, wbReg_i, branchResolved_i,
    input  stall_o, unitValid_o, opcode_o, primOperand_o, secOperand_o,
    input  pRead_o, pWrite_o, sRead_o, protocolError_o, issuedCount_o, stallCycles_o
  );

endinterface

// File: rtl/issue_scoreboard_reg_scoreboard.sv
// Busy-register vector: one-cycle update, set beats clear on the same index,
// two combinational lookups of the registered vector; never stalls.
module issue_scoreboard_reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] idx_a,
  output logic             busy_a,
  input  logic [IDX_W-1:0] idx_b,
  output logic             busy_b
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= (busy_q & ~clr_mask) | set_mask;
  end

  // Lookups see only the registered state: a writeback unblocks a reader one cycle later.
  assign busy_a = busy_q[idx_a];
  assign busy_b = busy_q[idx_b];

endmodule

// File: rtl/issue_scoreboard.sv
// Single-entry issue register with RAW scoreboard; issue fires in the cycle after accept
// at the earliest, stall_o holds decode while the entry is blocked or a branch is unresolved.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = NUM_ARCH_REGS,
  parameter int CNT_W    = 16
) (
  input  logic                clock_i,
  input  logic                reset_i,
  issue_scoreboard_if.slave   bus
);

  state_t           state, state_n;
  logic [6:0]       opcode_q;
  logic [1:0]       ftype_q;
  logic [REG_W-1:0] prim_q;
  logic [15:0]      sec_q;
  logic             pread_q, pwrite_q, sread_q;
  logic             proto_err_q;
  logic [CNT_W-1:0] issued_q, stall_cnt_q;

  logic             prim_busy, sec_busy, hazard;
  logic [2:0]       unit_valid;
  logic             fire, stall, accept, load;

  issue_scoreboard_reg_scoreboard #(.NUM_REGS(NUM_REGS), .IDX_W(REG_W)) u_sb (
    .clk     (clock_i),
    .rst     (reset_i),
    .set_en  (fire & pwrite_q),
    .set_idx (prim_q),
    .clr_en  (bus.wbEnable_i),
    .clr_idx (bus.wbReg_i),
    .idx_a   (prim_q),
    .busy_a  (prim_busy),
    .idx_b   (sec_q[REG_W-1:0]),
    .busy_b  (sec_busy)
  );

  always_comb begin
    hazard     = ((pread_q | pwrite_q) & prim_busy) | (sread_q & sec_busy);
    unit_valid = '0;
    if (state == ST_HOLD && !hazard) begin
      case (ftype_q)
        FT_ARITH:  unit_valid[U_ARITH]  = 1'b1;
        FT_LDST:   unit_valid[U_LDST]   = 1'b1;
        FT_BRANCH: unit_valid[U_BRANCH] = 1'b1;
        default:   ;
      endcase
    end
    fire   = |(unit_valid & bus.unitReady_i);
    stall  = (state == ST_HOLD && !fire) || (state == ST_BRANCH_WAIT);
    accept = bus.enable_i && !stall && (bus.functionType_i != FT_NOP);

    state_n = state;
    load    = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_n = ST_HOLD;
          load    = 1'b1;
        end
      end
      ST_HOLD: begin
        // A firing branch wins over an instruction offered in the same cycle.
        if (fire) begin
          if (ftype_q == FT_BRANCH) state_n = ST_BRANCH_WAIT;
          else if (accept)          load    = 1'b1;
          else                      state_n = ST_EMPTY;
        end
      end
      ST_BRANCH_WAIT: begin
        if (bus.branchResolved_i) state_n = ST_EMPTY;
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state       <= ST_EMPTY;
      opcode_q    <= '0;
      ftype_q     <= FT_NOP;
      prim_q      <= '0;
      sec_q       <= '0;
      pread_q     <= 1'b0;
      pwrite_q    <= 1'b0;
      sread_q     <= 1'b0;
      proto_err_q <= 1'b0;
      issued_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        opcode_q <= bus.opcode_i;
        ftype_q  <= bus.functionType_i;
        prim_q   <= bus.primOperand_i;
        sec_q    <= bus.secOperand_i;
        pread_q  <= bus.pRead_i;
        pwrite_q <= bus.pWrite_i;
        sread_q  <= bus.sRead_i;
      end
      if (bus.enable_i && stall) proto_err_q <= 1'b1;
      if (fire) issued_q <= issued_q + CNT_W'(1);
      if (stall && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_o         = stall;
  assign bus.unitValid_o     = unit_valid;
  assign bus.opcode_o        = opcode_q;
  assign bus.primOperand_o   = prim_q;
  assign bus.secOperand_o    = sec_q;
  assign bus.pRead_o         = pread_q;
  assign bus.pWrite_o        = pwrite_q;
  assign bus.sRead_o         = sread_q;
  assign bus.protocolError_o = proto_err_q;
  assign bus.issuedCount_o   = issued_q;
  assign bus.stallCycles_o   = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed vector table, hand sequences for corner cases,
// then random traffic against a behavioural reference model.
module tb_issue_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_scoreboard_if #(.CNT_W(16)) bus ();
  issue_scoreboard #(.NUM_REGS(32), .CNT_W(16)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [6:0]  op;
    logic [1:0]  ft;
    logic [4:0]  prim;
    logic [15:0] sec;
    logic        pr, pw, sr;
    logic [2:0]  rdy;
    logic        wb;
    logic [4:0]  wbreg;
    logic        br;
  } in_t;

  typedef struct {
    in_t        i;
    logic       stall;
    logic [2:0] uv;
    int         iss;
    int         sc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: what the stage holds, expressed as plain flags and arrays.
  bit          m_hold, m_bw, m_err;
  bit [31:0]   m_busy;
  logic [6:0]  m_op;
  logic [1:0]  m_ft;
  logic [4:0]  m_prim;
  logic [15:0] m_sec;
  bit          m_pr, m_pw, m_sr;
  int          m_iss, m_sc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void predict(input logic [2:0] rdy, output logic st, output logic [2:0] uv,
                                  output logic f);
    bit haz;
    haz = ((m_pr || m_pw) && m_busy[m_prim]) || (m_sr && m_busy[m_sec[4:0]]);
    uv  = 3'b000;
    if (m_hold && !haz) uv = 3'b001 << (m_ft - 2'd1);
    f   = (uv & rdy) != 3'b000;
    st  = (m_hold && !f) || m_bw;
  endfunction

  task automatic model_update(input in_t v);
    logic st, f;
    logic [2:0] uv;
    bit acc;
    if (v.rst) begin
      m_hold = 0; m_bw = 0; m_err = 0; m_busy = '0;
      m_op = '0; m_ft = '0; m_prim = '0; m_sec = '0;
      m_pr = 0; m_pw = 0; m_sr = 0; m_iss = 0; m_sc = 0;
      return;
    end
    predict(v.rdy, st, uv, f);
    acc = v.en && !st && (v.ft != 2'd0);
    if (v.en && st) m_err = 1;
    if (st && m_sc != 65535) m_sc++;
    if (v.wb) m_busy[v.wbreg] = 1'b0;
    if (f) begin
      m_iss = (m_iss + 1) % 65536;
      if (m_pw) m_busy[m_prim] = 1'b1;
    end
    if (m_bw) begin
      if (v.br) m_bw = 0;
    end else if (m_hold) begin
      if (f) begin
        if (m_ft == 2'd3) begin m_hold = 0; m_bw = 1; end
        else if (!acc) m_hold = 0;
      end
    end
    if (acc && (!m_hold || f) && !m_bw) begin
      if (!(f && m_ft == 2'd3)) begin
        m_hold = 1;
        m_op = v.op; m_ft = v.ft; m_prim = v.prim; m_sec = v.sec;
        m_pr = v.pr; m_pw = v.pw; m_sr = v.sr;
      end
    end
  endtask

  // Drive one cycle's inputs after the falling edge and compare settled outputs with the model.
  task automatic drive(input in_t v, input bit do_chk);
    logic st, f;
    logic [2:0] uv;
    @(negedge clk);
    rst                  = v.rst;
    bus.enable_i         = v.en;
    bus.opcode_i         = v.op;
    bus.functionType_i   = v.ft;
    bus.primOperand_i    = v.prim;
    bus.secOperand_i     = v.sec;
    bus.pRead_i          = v.pr;
    bus.pWrite_i         = v.pw;
    bus.sRead_i          = v.sr;
    bus.unitReady_i      = v.rdy;
    bus.wbEnable_i       = v.wb;
    bus.wbReg_i          = v.wbreg;
    bus.branchResolved_i = v.br;
    #1;
    if (do_chk) begin
      predict(v.rdy, st, uv, f);
      chk("stall", 64'(bus.stall_o), 64'(st));
      chk("unit_valid", 64'(bus.unitValid_o), 64'(uv));
      chk("fields", 64'({bus.opcode_o, bus.primOperand_o, bus.secOperand_o,
                         bus.pRead_o, bus.pWrite_o, bus.sRead_o}),
          64'({m_op, m_prim, m_sec, m_pr, m_pw, m_sr}));
      chk("protocol_error", 64'(bus.protocolError_o), 64'(m_err));
      chk("issued_count", 64'(bus.issuedCount_o), 64'(m_iss));
      chk("stall_cycles", 64'(bus.stallCycles_o), 64'(m_sc));
      chk("busy_vector", 64'(dut.u_sb.busy_q), 64'(m_busy));
    end
  endtask

  task automatic advance(input in_t v);
    @(posedge clk);
    model_update(v);
  endtask

  function automatic in_t mk(input bit en, input logic [1:0] ft, input logic [4:0] prim,
                             input bit pr, input bit pw, input bit sr, input logic [2:0] rdy);
    in_t v;
    v.rst = 0; v.en = en; v.ft = ft; v.prim = prim;
    v.op = (ft == 2'd1) ? 7'h33 : (ft == 2'd2) ? 7'h03 : (ft == 2'd3) ? 7'h63 : 7'h13;
    v.sec = 16'hBEE0 | 16'(prim); v.pr = pr; v.pw = pw; v.sr = sr; v.rdy = rdy;
    v.wb = 0; v.wbreg = '0; v.br = 0;
    return v;
  endfunction

  vec_t tbl[$];

  task automatic add(input in_t i, input logic st, input logic [2:0] uv, input int iss,
                     input int sc);
    vec_t e;
    e.i = i; e.stall = st; e.uv = uv; e.iss = iss; e.sc = sc;
    tbl.push_back(e);
  endtask

  initial begin
    in_t v, idle;
    logic st, f;
    logic [2:0] uv;

    idle = mk(0, 2'd0, 5'd0, 0, 0, 0, 3'b111);

    // Independent adds, RAW hazard, back-pressure, branch wait, nop.
    add(idle,                                  0, 3'b000, 0, 0);
    add(mk(1, 2'd1, 5'd1, 0, 1, 0, 3'b111),   0, 3'b000, 0, 0);
    add(mk(1, 2'd1, 5'd2, 0, 1, 0, 3'b111),   0, 3'b001, 0, 0);
    add(idle,                                  0, 3'b001, 1, 0);
    add(mk(1, 2'd1, 5'd3, 0, 1, 0, 3'b111),   0, 3'b000, 2, 0);
    add(mk(1, 2'd1, 5'd3, 1, 0, 0, 3'b111),   0, 3'b001, 2, 0);
    add(idle,                                  1, 3'b000, 3, 0);
    add(idle,                                  1, 3'b000, 3, 1);
    v = idle; v.wb = 1; v.wbreg = 5'd3;
    add(v,                                     1, 3'b000, 3, 2);
    add(idle,                                  0, 3'b001, 3, 3);
    add(mk(1, 2'd2, 5'd5, 0, 1, 0, 3'b101),   0, 3'b000, 4, 3);
    for (int k = 0; k < 4; k++) add(mk(0, 2'd0, 5'd0, 0, 0, 0, 3'b101), 1, 3'b010, 4, 3 + k);
    add(idle,                                  0, 3'b010, 4, 7);
    add(mk(1, 2'd3, 5'd0, 0, 0, 0, 3'b111),   0, 3'b000, 5, 7);
    add(idle,                                  0, 3'b100, 5, 7);
    for (int k = 0; k < 5; k++) add(idle, 1, 3'b000, 6, 7 + k);
    v = idle; v.br = 1;
    add(v,                                     1, 3'b000, 6, 12);
    add(mk(1, 2'd1, 5'd9, 0, 1, 0, 3'b111),   0, 3'b000, 6, 13);
    add(idle,                                  0, 3'b001, 6, 13);
    add(idle,                                  0, 3'b000, 7, 13);
    add(mk(1, 2'd0, 5'd4, 0, 1, 0, 3'b111),   0, 3'b000, 7, 13);
    add(idle,                                  0, 3'b000, 7, 13);

    v = idle; v.rst = 1;
    drive(v, 0); advance(v);
    drive(v, 0); advance(v);

    foreach (tbl[n]) begin
      drive(tbl[n].i, 1);
      chk($sformatf("tbl%0d_stall", n), 64'(bus.stall_o), 64'(tbl[n].stall));
      chk($sformatf("tbl%0d_uv", n), 64'(bus.unitValid_o), 64'(tbl[n].uv));
      chk($sformatf("tbl%0d_issued", n), 64'(bus.issuedCount_o), 64'(tbl[n].iss));
      chk($sformatf("tbl%0d_stallcyc", n), 64'(bus.stallCycles_o), 64'(tbl[n].sc));
      advance(tbl[n].i);
    end

    // Fire with pWrite on r7 while writeback clears r7: set must win.
    v = mk(1, 2'd1, 5'd7, 0, 1, 0, 3'b111);
    drive(v, 1); advance(v);
    v = idle; v.wb = 1; v.wbreg = 5'd7;
    drive(v, 1);
    chk("collision_fire", 64'(bus.unitValid_o), 64'(3'b001));
    advance(v);
    drive(idle, 1);
    chk("collision_busy7", 64'(dut.u_sb.busy_q[7]), 64'(1));
    advance(idle);

    // enable_i during stall raises a sticky protocol error.
    v = mk(1, 2'd2, 5'd8, 0, 1, 0, 3'b101);
    drive(v, 1); advance(v);
    v = mk(0, 2'd0, 5'd0, 0, 0, 0, 3'b101);
    drive(v, 1); advance(v);
    v = mk(1, 2'd1, 5'd10, 0, 1, 0, 3'b101);
    drive(v, 1);
    chk("proto_stall_seen", 64'(bus.stall_o), 64'(1));
    advance(v);
    v = mk(0, 2'd0, 5'd0, 0, 0, 0, 3'b101);
    drive(v, 1);
    chk("proto_err_set", 64'(bus.protocolError_o), 64'(1));
    advance(v);
    drive(v, 1);
    chk("proto_err_sticky", 64'(bus.protocolError_o), 64'(1));
    chk("proto_still_held", 64'(bus.unitValid_o), 64'(3'b010));
    advance(v);

    // Reset while an instruction is held.
    v.rst = 1;
    drive(v, 1); advance(v);
    drive(idle, 1);
    chk("rst_stall", 64'(bus.stall_o), 64'(0));
    chk("rst_uv", 64'(bus.unitValid_o), 64'(0));
    chk("rst_err", 64'(bus.protocolError_o), 64'(0));
    chk("rst_counts", 64'({bus.issuedCount_o, bus.stallCycles_o}), 64'(0));
    chk("rst_busy", 64'(dut.u_sb.busy_q), 64'(0));
    chk("rst_fields", 64'({bus.opcode_o, bus.primOperand_o, bus.secOperand_o}), 64'(0));
    advance(idle);

    for (int n = 0; n < 3000; n++) begin
      v.rst   = ($urandom_range(0, 299) == 0);
      v.rdy   = 3'($urandom_range(0, 7));
      v.ft    = 2'($urandom_range(0, 3));
      v.op    = 7'($urandom);
      v.prim  = 5'($urandom_range(0, 7));
      v.sec   = (16'($urandom) & 16'hFFE0) | 16'($urandom_range(0, 7));
      v.pr    = 1'($urandom);
      v.pw    = 1'($urandom);
      v.sr    = 1'($urandom);
      v.wb    = ($urandom_range(0, 2) == 0);
      v.wbreg = 5'($urandom_range(0, 7));
      v.br    = ($urandom_range(0, 3) == 0);
      predict(v.rdy, st, uv, f);
      v.en    = st ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 2) != 0);
      drive(v, 1);
      advance(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
